// File: rtl/running_stats_pkg.sv
// Shared helpers for the running-statistics blocks: counter sizing and
// width-agnostic compare selectors operating on sign- or zero-extended values.
package running_stats_pkg;

    localparam int unsigned MaxWidth = 64;

    typedef logic [MaxWidth-1:0] wide_t;

    function automatic int unsigned fill_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Callers widen their operands first (sign-extended when signed_mode is set).
    function automatic wide_t max_sel(input wide_t a, input wide_t b, input bit signed_mode);
        if (signed_mode) begin
            return ($signed(a) > $signed(b)) ? a : b;
        end
        return (a > b) ? a : b;
    endfunction

    function automatic wide_t min_sel(input wide_t a, input wide_t b, input bit signed_mode);
        if (signed_mode) begin
            return ($signed(a) < $signed(b)) ? a : b;
        end
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/extrema_tree.sv
// Balanced pairwise max/min reduction over DEPTH slots; unoccupied slots
// contribute the identity element so they can never win a comparison.
module extrema_tree
    import running_stats_pkg::*;
#(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned SIGNED = 0
) (
    input  logic [DEPTH-1:0][WIDTH-1:0] vals,
    input  logic [DEPTH-1:0]            occ,
    output logic [WIDTH-1:0]            max_val,
    output logic [WIDTH-1:0]            min_val
);

    localparam int unsigned Levels = $clog2(DEPTH);
    localparam int unsigned Leaves = 1 << Levels;
    localparam bit          SMode  = (SIGNED != 0);

    // Most negative value is the max identity; its complement is the min identity.
    localparam logic [WIDTH-1:0] MaxId = SMode ? (WIDTH'(1) << (WIDTH - 1)) : '0;
    localparam logic [WIDTH-1:0] MinId = ~MaxId;

    function automatic wide_t widen(input logic [WIDTH-1:0] v);
        return SMode ? wide_t'($signed(v)) : wide_t'(v);
    endfunction

    for (genvar l = 0; l <= Levels; l++) begin : g_lvl
        localparam int unsigned N = Leaves >> l;
        logic [WIDTH-1:0] mx [N];
        logic [WIDTH-1:0] mn [N];

        if (l == 0) begin : g_leaf
            for (genvar j = 0; j < N; j++) begin : g_slot
                if (j < DEPTH) begin : g_real
                    assign mx[j] = occ[j] ? vals[j] : MaxId;
                    assign mn[j] = occ[j] ? vals[j] : MinId;
                end else begin : g_pad
                    assign mx[j] = MaxId;
                    assign mn[j] = MinId;
                end
            end
        end else begin : g_node
            for (genvar k = 0; k < N; k++) begin : g_pair
                assign mx[k] = WIDTH'(max_sel(widen(g_lvl[l-1].mx[2*k]),
                                              widen(g_lvl[l-1].mx[2*k+1]), SMode));
                assign mn[k] = WIDTH'(min_sel(widen(g_lvl[l-1].mn[2*k]),
                                              widen(g_lvl[l-1].mn[2*k+1]), SMode));
            end
        end
    end

    assign max_val = g_lvl[Levels].mx[0];
    assign min_val = g_lvl[Levels].mn[0];

endmodule

// File: rtl/running_window_extrema.sv
// Sliding-window max/min tracker over the last DEPTH accepted samples; the
// reduction sees next-state window contents so results land on the accepting edge.
module running_window_extrema
    import running_stats_pkg::*;
#(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned SIGNED = 0
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    input  logic [WIDTH-1:0]                 data_in,
    input  logic                             clear,
    output logic [WIDTH-1:0]                 high_out,
    output logic [WIDTH-1:0]                 low_out,
    output logic                             out_valid,
    output logic [fill_width(DEPTH)-1:0]     fill_count,
    output logic                             window_full
);

    localparam int unsigned CntW = fill_width(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] slot_q, slot_d;
    logic [DEPTH-1:0]            occ_q, occ_d;
    logic [CntW-1:0]             fill_d;
    logic [WIDTH-1:0]            high_next, low_next;

    always_comb begin
        slot_d = slot_q;
        occ_d  = occ_q;
        fill_d = fill_count;
        if (clear) begin
            occ_d  = '0;
            fill_d = '0;
        end
        if (in_valid) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                slot_d[i] = slot_q[i-1];
                occ_d[i]  = clear ? 1'b0 : occ_q[i-1];
            end
            slot_d[0] = data_in;
            occ_d[0]  = 1'b1;
            if (clear) begin
                fill_d = CntW'(1);
            end else if (fill_count != CntW'(DEPTH)) begin
                fill_d = fill_count + CntW'(1);
            end
        end
    end

    extrema_tree #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .SIGNED(SIGNED)
    ) u_tree (
        .vals   (slot_d),
        .occ    (occ_d),
        .max_val(high_next),
        .min_val(low_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_q     <= '0;
            occ_q      <= '0;
            fill_count <= '0;
            high_out   <= '0;
            low_out    <= '0;
            out_valid  <= 1'b0;
        end else begin
            slot_q     <= slot_d;
            occ_q      <= occ_d;
            fill_count <= fill_d;
            out_valid  <= in_valid;
            if (in_valid) begin
                high_out <= high_next;
                low_out  <= low_next;
            end
        end
    end

    assign window_full = (fill_count == CntW'(DEPTH));

endmodule

// File: tb/tb_running_window_extrema.sv
// Directed bench: unsigned and signed WIDTH=4, DEPTH=4 instances share one stimulus stream.
module tb_running_window_extrema;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] data_in = '0;
    logic       clear = 1'b0;

    logic [3:0] u_high, u_low, s_high, s_low;
    logic       u_ov, u_wf, s_ov, s_wf;
    logic [2:0] u_fill, s_fill;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    running_window_extrema #(.WIDTH(4), .DEPTH(4), .SIGNED(0)) dut_u (
        .clk(clk), .reset(reset), .in_valid(in_valid), .data_in(data_in), .clear(clear),
        .high_out(u_high), .low_out(u_low), .out_valid(u_ov), .fill_count(u_fill),
        .window_full(u_wf)
    );

    running_window_extrema #(.WIDTH(4), .DEPTH(4), .SIGNED(1)) dut_s (
        .clk(clk), .reset(reset), .in_valid(in_valid), .data_in(data_in), .clear(clear),
        .high_out(s_high), .low_out(s_low), .out_valid(s_ov), .fill_count(s_fill),
        .window_full(s_wf)
    );

    // {high, low, fill, out_valid, window_full}
    function automatic logic [12:0] pack(input logic [3:0] h, input logic [3:0] l,
                                         input logic [2:0] f, input logic v, input logic w);
        return {h, l, f, v, w};
    endfunction

    task automatic step(input logic v, input logic [3:0] d, input logic c, input logic r);
        @(negedge clk);
        in_valid = v;
        data_in  = d;
        clear    = c;
        reset    = r;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [12:0] got;
        step(1'b1, 4'hA, 1'b0, 1'b1);
        step(1'b1, 4'h5, 1'b1, 1'b1);
        got = pack(u_high, u_low, u_fill, u_ov, u_wf);
        checks++;
        if (got !== pack(4'h0, 4'h0, 3'd0, 1'b0, 1'b0)) begin
            failures++;
            $display("FAIL reset_unsigned got=%h want=%h", got, pack(0, 0, 0, 0, 0));
        end
        got = pack(s_high, s_low, s_fill, s_ov, s_wf);
        checks++;
        if (got !== pack(4'h0, 4'h0, 3'd0, 1'b0, 1'b0)) begin
            failures++;
            $display("FAIL reset_signed got=%h want=%h", got, pack(0, 0, 0, 0, 0));
        end
    endtask

    task automatic test_fill();
        logic [3:0] din [4]  = '{4'd3, 4'd9, 4'd2, 4'd5};
        logic [3:0] hi  [4]  = '{4'd3, 4'd9, 4'd9, 4'd9};
        logic [3:0] lo  [4]  = '{4'd3, 4'd3, 4'd2, 4'd2};
        logic [12:0] got, want;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, din[i], 1'b0, 1'b0);
            got  = pack(u_high, u_low, u_fill, u_ov, u_wf);
            want = pack(hi[i], lo[i], 3'(i + 1), 1'b1, (i == 3));
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL fill[%0d] got=%h want=%h", i, got, want);
            end
        end
    endtask

    task automatic test_eviction();
        logic [3:0] din [4] = '{4'd1, 4'd4, 4'd6, 4'd0};
        logic [3:0] hi  [4] = '{4'd9, 4'd5, 4'd6, 4'd6};
        logic [3:0] lo  [4] = '{4'd1, 4'd1, 4'd1, 4'd0};
        logic [12:0] got, want;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, din[i], 1'b0, 1'b0);
            got  = pack(u_high, u_low, u_fill, u_ov, u_wf);
            want = pack(hi[i], lo[i], 3'd4, 1'b1, 1'b1);
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL evict[%0d] got=%h want=%h", i, got, want);
            end
        end
    endtask

    task automatic test_gaps_and_clear();
        logic [12:0] got, want;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 4'hF, 1'b0, 1'b0);
            got  = pack(u_high, u_low, u_fill, u_ov, u_wf);
            want = pack(4'd6, 4'd0, 3'd4, 1'b0, 1'b1);
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL idle[%0d] got=%h want=%h", i, got, want);
            end
        end
        step(1'b0, 4'hF, 1'b1, 1'b0);
        got  = pack(u_high, u_low, u_fill, u_ov, u_wf);
        want = pack(4'd6, 4'd0, 3'd0, 1'b0, 1'b0);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL clear_only got=%h want=%h", got, want);
        end
        step(1'b1, 4'd7, 1'b1, 1'b0);
        got  = pack(u_high, u_low, u_fill, u_ov, u_wf);
        want = pack(4'd7, 4'd7, 3'd1, 1'b1, 1'b0);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL clear_and_valid got=%h want=%h", got, want);
        end
        // Stale slots (6,4,0) must stay invisible after the flush.
        step(1'b1, 4'd3, 1'b0, 1'b0);
        got  = pack(u_high, u_low, u_fill, u_ov, u_wf);
        want = pack(4'd7, 4'd3, 3'd2, 1'b1, 1'b0);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL after_clear got=%h want=%h", got, want);
        end
    endtask

    task automatic test_signed();
        logic [12:0] got, want;
        step(1'b0, 4'h0, 1'b0, 1'b1);
        step(1'b1, 4'hF, 1'b0, 1'b0);
        step(1'b1, 4'h7, 1'b0, 1'b0);
        step(1'b1, 4'h8, 1'b0, 1'b0);
        got  = pack(s_high, s_low, s_fill, s_ov, s_wf);
        want = pack(4'h7, 4'h8, 3'd3, 1'b1, 1'b0);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL signed_mode got=%h want=%h", got, want);
        end
        got  = pack(u_high, u_low, u_fill, u_ov, u_wf);
        want = pack(4'hF, 4'h7, 3'd3, 1'b1, 1'b0);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL unsigned_mode got=%h want=%h", got, want);
        end
    endtask

    task automatic test_reset_mid_stream();
        logic [12:0] got, want;
        step(1'b0, 4'h0, 1'b0, 1'b1);
        step(1'b1, 4'd2, 1'b0, 1'b0);
        got  = pack(u_high, u_low, u_fill, u_ov, u_wf);
        want = pack(4'd2, 4'd2, 3'd1, 1'b1, 1'b0);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL mid_reset_first got=%h want=%h", got, want);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 4'd1, 1'b0, 1'b0);
            got  = pack(u_high, u_low, u_fill, u_ov, u_wf);
            want = pack((i == 3) ? 4'd1 : 4'd2, 4'd1, (i == 0) ? 3'd2 : (i == 1) ? 3'd3 : 3'd4,
                        1'b1, (i >= 2));
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL mid_reset_ones[%0d] got=%h want=%h", i, got, want);
            end
        end
        // Signed instance saw the same stream.
        got  = pack(s_high, s_low, s_fill, s_ov, s_wf);
        want = pack(4'd1, 4'd1, 3'd4, 1'b1, 1'b1);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL mid_reset_signed got=%h want=%h", got, want);
        end
        step(1'b0, 4'd9, 1'b0, 1'b0);
        checks++;
        if (u_ov !== 1'b0) begin
            failures++;
            $display("FAIL pulse_drop got=%b want=0", u_ov);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_eviction();
        test_gaps_and_clear();
        test_signed();
        test_reset_mid_stream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
